// File: rtl/klotski_sort_ctrl.sv
// klotski_sort_ctrl: sequences the RGB tile sorter for the klotski camera path.
// The controller latches a frame of 16 tile colours and starts the sorter. It
// waits for done under a timeout and checks that the returned labelling is a
// permutation of 0..15. A labelling must repeat over consecutive frames before
// it is published to the solver over a valid/ready handshake.
//
// Optional build macro: SORT_CTRL_ERRCNT_EN adds o_err_cnt, a saturating count
// of timeout and invalid-result events that is cleared on each publish handshake.
//
// Handshake (o_order_valid / i_order_ready): o_order_valid rises with o_order
// already loaded. Both hold steady until a cycle in which i_order_ready=1. That
// cycle is the transfer. o_order_valid is low on the following cycle, and
// o_order keeps its last published value.
module klotski_sort_ctrl #(
  parameter int STABLE_CNT = 3,   // identical valid results required to publish (1..15)
  parameter int TIMEOUT    = 64   // cycles allowed in S_WAIT (32..255)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_frame_valid,
  input  logic [383:0] i_blocks,
  output logic [383:0] o_sort_block,
  output logic         o_sort_start,
  input  logic         i_sort_done,
  input  logic [63:0]  i_sort_order,
  output logic         o_order_valid,
  output logic [63:0]  o_order,
  input  logic         i_order_ready,
  output logic         o_busy,
  output logic         o_timeout,
  output logic         o_invalid
`ifdef SORT_CTRL_ERRCNT_EN
  ,
  output logic [7:0]   o_err_cnt
`endif
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] STB_MAX  = 4'(STABLE_CNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [383:0]   blk_q;
  logic [63:0]    res_q, res_d;
  logic [63:0]    cand_q, cand_d;
  logic [3:0]     stab_q, stab_d;
  logic [7:0]     tmo_q, tmo_d;
  logic [63:0]    order_q, order_d;

  logic           done_hit;
  logic           tmo_hit;
  logic           in_check;
  logic           same_cand;
  logic           perm_ok;
  logic           publish;
  logic [15:0]    seen;

  // A sorter done only counts while waiting, and it beats a coincident timeout.
  assign done_hit  = (state_q == S_WAIT) && i_sort_done;
  assign tmo_hit   = (state_q == S_WAIT) && !i_sort_done && (tmo_q == TMO_LAST);
  assign in_check  = (state_q == S_CHECK);
  assign same_cand = (res_q == cand_q);

  // Permutation check: the one-hot decodes of all 16 nibbles must cover every label.
  always_comb begin
    seen = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      seen = seen | (16'h0001 << res_q[4*i +: 4]);
    end
  end
  assign perm_ok = &seen;

  // Debounce: track the current candidate and how many times in a row it has been seen.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (tmo_hit) begin
      stab_d = 4'd0;
    end else if (in_check) begin
      if (!perm_ok) begin
        stab_d = 4'd0;
      end else if (same_cand) begin
        stab_d = (stab_q == STB_MAX) ? STB_MAX : stab_q + 4'd1;
      end else begin
        cand_d = res_q;
        stab_d = 4'd1;
      end
    end
  end

  // Publish only on arrival at STABLE_CNT. A changed result that lands there
  // straight away (STABLE_CNT=1) also arrives. A saturated hold does not publish.
  assign publish = in_check && perm_ok && (stab_d == STB_MAX) &&
                   (!same_cand || (stab_q != STB_MAX));

  // Result capture, timeout counter and published order next values.
  always_comb begin
    res_d   = res_q;
    tmo_d   = tmo_q;
    order_d = order_q;
    if (state_q == S_START) begin
      tmo_d = 8'd0;
    end else if (state_q == S_WAIT) begin
      if (i_sort_done) begin
        res_d = i_sort_order;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
    if (publish) begin
      order_d = cand_d;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_frame_valid) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (done_hit)     state_d = S_CHECK;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_CHECK: state_d = publish ? S_OUT : S_IDLE;
      S_OUT:   if (i_order_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    o_sort_start  = (state_q == S_START);
    o_busy        = (state_q != S_IDLE);
    o_order_valid = (state_q == S_OUT);
    o_timeout     = tmo_hit;
    o_invalid     = in_check && !perm_ok;
  end

  // Datapath registers: frame capture, result, candidate, counters, published order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blk_q   <= '0;
      res_q   <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      tmo_q   <= '0;
      order_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && i_frame_valid) begin
        blk_q <= i_blocks;
      end
      res_q   <= res_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      order_q <= order_d;
    end
  end

  assign o_sort_block = blk_q;
  assign o_order      = order_q;

`ifdef SORT_CTRL_ERRCNT_EN
  logic [7:0] err_q;

  // Error counter: saturating count of timeouts and invalid results, cleared on transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 8'd0;
    end else if ((state_q == S_OUT) && i_order_ready) begin
      err_q <= 8'd0;
    end else if ((tmo_hit || (in_check && !perm_ok)) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign o_err_cnt = err_q;
`endif

endmodule
